// File: rtl/pulse_monitor.sv
// Pulse monitor: synchronizes an asynchronous input, strobes its edges and
// measures half-periods in ticks, flagging loss of pulse after a tick limit.
module pulse_monitor #(
  parameter int         pSysClk       = 25000000,
  parameter logic [7:0] pTimeoutTicks = 8'd255,
  parameter logic       pIdleLevel    = 1'b1
) (
  input  logic       iSysClk,
  input  logic       iSysRst,
  input  logic       iPulse,
  input  logic       iClr,
  output logic       oLevel,
  output logic       oRise,
  output logic       oFall,
  output logic [7:0] oPeriod,
  output logic       oPeriodVld,
  output logic       oTimeout
);

  localparam int              TW        = $clog2(pSysClk + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(pSysClk - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_e;

  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    period_q, period_d;
  logic          vld_q, vld_d;
  logic          timeout_q, timeout_d;
  state_e        state_q, state_d;

  logic q_rise, q_fall, q_edge, q_tick;

  always_comb begin
    s1_d   = iPulse;
    s2_d   = s1_q;
    s3_d   = s2_q;
    q_rise = s2_q & ~s3_q;
    q_fall = ~s2_q & s3_q;
    q_edge = q_rise | q_fall;
    rise_d = q_rise;
    fall_d = q_fall;
    q_tick = (tick_cnt_q == TICK_LAST);
  end

  // An edge restarts the tick phase so ticks are counted from the last edge.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (iClr || q_edge || q_tick) tick_cnt_d = '0;
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    timeout_d = timeout_q;
    if (iClr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      period_d  = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (q_edge) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        MEASURE: begin
          // The edge wins over the limit check; a tick on the edge cycle counts.
          if (q_edge) begin
            period_d = cnt_q + {7'd0, q_tick};
            vld_d    = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == pTimeoutTicks) begin
            state_d   = LOST;
            timeout_d = 1'b1;
          end else if (q_tick) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        LOST: begin
          if (q_edge) begin
            state_d   = MEASURE;
            cnt_d     = '0;
            timeout_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same clock edge regardless of statement order.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      s1_q       <= pIdleLevel;
      s2_q       <= pIdleLevel;
      s3_q       <= pIdleLevel;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      timeout_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      timeout_q  <= timeout_d;
      state_q    <= state_d;
    end
  end

  assign oLevel     = s2_q;
  assign oRise      = rise_q;
  assign oFall      = fall_q;
  assign oPeriod    = period_q;
  assign oPeriodVld = vld_q;
  assign oTimeout   = timeout_q;

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- pSysClk, 25000000, system clocks per measurement tick, at least 2.
- pTimeoutTicks, 8'd255, tick count with no edge that declares loss of pulse, range 1..255.
- pIdleLevel, 1'b1, level preloaded into the synchronizer and edge registers at reset.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- iSysClk, in, 1, system clock; the only clock.
- iSysRst, in, 1, reset; asynchronous, active-low.
- iPulse, in, 1, asynchronous pulse/toggle input under measurement.
- iClr, in, 1, synchronous clear, active-high.
- oLevel, out, 1, synchronized level of iPulse.
- oRise, out, 1, one-cycle strobe on a detected rising edge.
- oFall, out, 1, one-cycle strobe on a detected falling edge.
- oPeriod, out, 8, last measured half-period, in ticks.
- oPeriodVld, out, 1, one-cycle strobe marking an oPeriod update.
- oTimeout, out, 1, level; no edge seen for pTimeoutTicks ticks.

Function
REQ-003 iPulse SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3; oLevel SHALL equal s2.

REQ-004 Edge detection SHALL be qRise = s2 & ~s3 and qFall = ~s2 & s3; oRise and oFall SHALL be these values registered.
- Resulting latency: a stable iPulse change meeting setup before clock edge k produces a strobe high after edge k+2, for exactly one cycle.

REQ-005 The tick counter SHALL count 0..pSysClk-1 and wrap to 0, with width derived from the MSB position of pSysClk.
- qTick is asserted when the count equals pSysClk-1.
- A detected edge (qRise|qFall) SHALL force the tick counter to 0 in that cycle, so ticks stay phase-aligned to the last edge.

REQ-006 The FSM SHALL have three states: IDLE, MEASURE and LOST.

REQ-007 In IDLE, the first detected edge SHALL move the FSM to MEASURE, clear the half-period counter to 0, and produce no oPeriodVld.

REQ-008 In MEASURE, the 8-bit half-period counter SHALL increment on each qTick. On a detected edge the block SHALL:
- load oPeriod with counter+qTick, so a tick coincident with the edge is counted;
- pulse oPeriodVld for one cycle;
- clear the counter to 0 and remain in MEASURE.

REQ-009 In MEASURE, when the counter equals pTimeoutTicks and no edge is detected in that cycle, the FSM SHALL:
- move to LOST;
- set oTimeout to 1 on the next cycle;
- hold the counter;
- leave oPeriod unchanged.

REQ-010 If an edge and the timeout condition occur in the same cycle, the edge SHALL win: REQ-008 applies and no timeout is raised.

REQ-011 In LOST, a detected edge SHALL:
- clear oTimeout;
- clear the counter to 0;
- return the FSM to MEASURE;
- produce no oPeriodVld, because the interval was interrupted.

REQ-012 Because of REQ-009, the counter SHALL never exceed pTimeoutTicks; no wrap-around or saturation path SHALL exist.

REQ-013 iClr SHALL take priority over all other FSM and counter updates and, in the cycle after it is sampled high, SHALL leave:
- the FSM in IDLE;
- the tick and half-period counters at 0;
- oPeriod at 0, and oTimeout and oPeriodVld at 0.
The synchronizer and edge strobes SHALL continue to operate during iClr.

REQ-014 oRise, oFall and oPeriodVld SHALL never be high for two consecutive cycles from a single edge.

Reset
REQ-015 While iSysRst is 0, the following SHALL be forced asynchronously:
- s1, s2 and s3 to pIdleLevel;
- oLevel to pIdleLevel;
- all other outputs and counters to 0;
- the FSM to IDLE.

REQ-016 On reset release, no oRise or oFall SHALL be generated if iPulse already equals pIdleLevel.

REQ-017 Reset asserted mid-measurement SHALL discard the partial count, and no oPeriodVld SHALL be emitted for it.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Basic measurement (pSysClk=4, pTimeoutTicks=10): iPulse toggles every 20 clocks -> after the first edge, every edge gives oPeriodVld with oPeriod=5, and oRise and oFall alternate.
- Timeout (same parameters): toggle three times, then hold iPulse -> oTimeout rises 40 clocks (10 ticks) after the last detected edge, and oPeriod keeps 5.
- Recovery: from LOST, toggle every 12 clocks -> the first edge clears oTimeout with no oPeriodVld; subsequent edges give oPeriod=3.
- Simultaneous events: place an edge exactly on the cycle where the counter reaches pTimeoutTicks=10 -> oPeriodVld with oPeriod=10 and oTimeout stays 0.
- Reset and clear: pulse iClr mid-measurement -> FSM in IDLE, oPeriod=0, and the next edge gives no oPeriodVld. Assert iSysRst low asynchronously between clock edges -> outputs clear immediately, and no spurious edge strobe after release with iPulse=1.
- Latency: a single iPulse step -> oRise high for exactly one cycle, after the third iSysClk rising edge.
